// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: IDELAY tap sweep and lock controller for a four-phase data
// recovery unit. Each tap is loaded, left to settle, then one window of DRU
// edge flags is counted. A window is good when enough edges are seen and one
// sample phase holds at least three quarters of them. After lock the same tap
// keeps being measured, and two bad windows in a row resume the sweep.
//
// Optional build macro: RX_ALIGN_STATS_EN adds the win_total, win_peak and
// relock_cnt outputs.
//
// state      | meaning
// -----------+----------------------------------------------------------
// WAIT_RDY   | idle until the IDELAYCTRL reports ready
// LOAD       | one-cycle tap_ld strobe with the current tap_val
// SETTLE     | SETTLE idle cycles while the delay line settles; E ignored
// MEASURE    | 2^WIN_LOG2-cycle edge count window at an unlocked tap
// EVAL       | one-cycle good/bad decision on the finished window
// LOCKED     | locked; back-to-back monitoring windows at the same tap

module rx_align_ctrl #(
   parameter int TAP_W     = 5,
   parameter int WIN_LOG2  = 10,
   parameter int SETTLE    = 16,
   parameter int MIN_EDGES = 64
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             dly_rdy,
   input  logic [3:0]       E,
   output logic             tap_ld,
   output logic [TAP_W-1:0] tap_val,
   output logic             locked,
   output logic             sweep_fail
`ifdef RX_ALIGN_STATS_EN
  ,output logic [WIN_LOG2+2:0] win_total,
   output logic [1:0]          win_peak,
   output logic [7:0]          relock_cnt
`endif
);

   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int TOT_W = WIN_LOG2 + 3;
   localparam int CMP_W = TOT_W + 2;
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int TMR_W = (WIN_LOG2 > SET_W) ? WIN_LOG2 : SET_W;
   localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] WIN_LD = TMR_W'((2 ** WIN_LOG2) - 1);

   typedef enum logic [2:0] {
      S_WAIT_RDY,
      S_LOAD,
      S_SETTLE,
      S_MEASURE,
      S_EVAL,
      S_LOCKED
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [TMR_W-1:0]   r_tmr;
   logic [CNT_W-1:0]   r_bucket [4];
   logic [TOT_W-1:0]   r_total;
   logic [TAP_W-1:0]   r_tap;
   logic               r_locked;
   logic               r_sweep_fail;
   logic               r_bad;

   logic               w_abort;
   logic               w_tmr_done;
   logic [2:0]         w_pop;
   logic [CNT_W-1:0]   w_max;
   logic [CMP_W-1:0]   w_max4;
   logic [CMP_W-1:0]   w_tot3;
   logic               w_good;
   logic               w_resweep;

   assign tap_val    = r_tap;
   assign locked     = r_locked;
   assign sweep_fail = r_sweep_fail;

   // Losing IDELAYCTRL ready anywhere past WAIT_RDY restarts from WAIT_RDY.
   assign w_abort    = (r_state != S_WAIT_RDY) && !dly_rdy;
   assign w_tmr_done = (r_tmr == '0);
   assign w_pop      = {2'b00, E[0]} + {2'b00, E[1]} + {2'b00, E[2]} + {2'b00, E[3]};

   // Largest bucket of the finished window.
   always_comb begin
      w_max = r_bucket[0];
      for (int i = 1; i < 4; i++) begin
         if (r_bucket[i] > w_max) w_max = r_bucket[i];
      end
   end

   // Window quality: both sides widened so 4*max and 3*total never truncate.
   always_comb begin
      w_max4 = CMP_W'({w_max, 2'b00});
      w_tot3 = CMP_W'(r_total) + CMP_W'({r_total, 1'b0});
      w_good = (32'(r_total) >= 32'(MIN_EDGES)) && (w_max4 >= w_tot3);
   end

   // A bad window moves on to the next tap unless it is the first miss after lock.
   assign w_resweep = !w_good && (!r_locked || r_bad);

   // State register.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) r_state <= S_WAIT_RDY;
      else          r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = S_WAIT_RDY;
      end else begin
         case (r_state)
            S_WAIT_RDY: if (dly_rdy) w_next = S_LOAD;
            S_LOAD:     w_next = S_SETTLE;
            S_SETTLE:   if (w_tmr_done) w_next = S_MEASURE;
            S_MEASURE:  if (w_tmr_done) w_next = S_EVAL;
            S_EVAL:     w_next = w_resweep ? S_LOAD : S_LOCKED;
            S_LOCKED:   if (w_tmr_done) w_next = S_EVAL;
            default:    w_next = S_WAIT_RDY;
         endcase
      end
   end

   // Outputs decoded from state only, so E has no path to any port.
   always_comb begin
      tap_ld = 1'b0;
      if (r_state == S_LOAD) tap_ld = 1'b1;
   end

   // Timer, edge counters, tap and lock bookkeeping.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_tmr        <= '0;
         r_total      <= '0;
         r_tap        <= '0;
         r_locked     <= 1'b0;
         r_sweep_fail <= 1'b0;
         r_bad        <= 1'b0;
         for (int i = 0; i < 4; i++) r_bucket[i] <= '0;
      end else if (w_abort) begin
         r_tmr    <= '0;
         r_total  <= '0;
         r_locked <= 1'b0;
         r_bad    <= 1'b0;
         for (int i = 0; i < 4; i++) r_bucket[i] <= '0;
      end else begin
         case (r_state)
            S_LOAD: r_tmr <= SET_LD;
            S_SETTLE: begin
               if (w_tmr_done) begin
                  r_tmr   <= WIN_LD;
                  r_total <= '0;
                  for (int i = 0; i < 4; i++) r_bucket[i] <= '0;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            S_MEASURE, S_LOCKED: begin
               r_tmr   <= r_tmr - TMR_W'(1);
               r_total <= r_total + TOT_W'(w_pop);
               for (int i = 0; i < 4; i++) r_bucket[i] <= r_bucket[i] + CNT_W'(E[i]);
            end
            S_EVAL: begin
               r_tmr   <= WIN_LD;
               r_total <= '0;
               for (int i = 0; i < 4; i++) r_bucket[i] <= '0;
               if (w_good) begin
                  r_locked <= 1'b1;
                  r_bad    <= 1'b0;
               end else if (w_resweep) begin
                  r_locked <= 1'b0;
                  r_bad    <= 1'b0;
                  r_tap    <= r_tap + TAP_W'(1);
                  if (r_tap == '1) r_sweep_fail <= 1'b1;
               end else begin
                  r_bad <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RX_ALIGN_STATS_EN
   logic [1:0] w_peak_idx;

   // Index of the largest bucket; strict compare keeps the lowest index on ties.
   always_comb begin
      w_peak_idx = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (r_bucket[i] > r_bucket[w_peak_idx]) w_peak_idx = 2'(i);
      end
   end

   // Window statistics captured at each decision.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         win_total  <= '0;
         win_peak   <= '0;
         relock_cnt <= '0;
      end else if (r_state == S_EVAL && !w_abort) begin
         win_total <= r_total;
         win_peak  <= w_peak_idx;
         if (r_locked && w_resweep && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Bench for rx_align_ctrl: expected tap loads are queued by the stimulus and
// checked by an independent monitor on every tap_ld pulse.
module tb_rx_align_ctrl;

   localparam int M_ZERO   = 0;
   localparam int M_SPREAD = 1;
   localparam int M_CLEAN  = 2;
   localparam int M_SWEEP  = 3;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic       dly_rdy = 1'b0;
   logic [3:0] E = 4'b0000;
   logic       tap_ld;
   logic [4:0] tap_val;
   logic       locked;
   logic       sweep_fail;
`ifdef RX_ALIGN_STATS_EN
   logic [12:0] win_total;
   logic [1:0]  win_peak;
   logic [7:0]  relock_cnt;
`endif

   int n_chk = 0;
   int n_pass = 0;
   int n_ld = 0;
   int exp_q[$];
   int mode = M_ZERO;
   int lock_tap = 0;
   int clean_kind = 0;
   int phase = 0;
   int cyc;

   rx_align_ctrl dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .dly_rdy    (dly_rdy),
      .E          (E),
      .tap_ld     (tap_ld),
      .tap_val    (tap_val),
      .locked     (locked),
      .sweep_fail (sweep_fail)
`ifdef RX_ALIGN_STATS_EN
     ,.win_total  (win_total),
      .win_peak   (win_peak),
      .relock_cnt (relock_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [3:0] clean_e();
      if (clean_kind == 1) return 4'b0100;
      return (phase % 4 == 0) ? 4'b0010 : 4'b0000;
   endfunction

   function automatic logic [3:0] spread_e();
      logic [3:0] v;
      v = 4'b0001 << (phase % 4);
      return v;
   endfunction

   function automatic logic [3:0] gen_e();
      case (mode)
         M_SPREAD: return spread_e();
         M_CLEAN:  return clean_e();
         M_SWEEP:  return (int'(tap_val) < lock_tap) ? spread_e() : clean_e();
         default:  return 4'b0000;
      endcase
   endfunction

   // Scoreboard monitor: every load strobe must match the next queued tap.
   always @(negedge clk) begin
      if (aresetn && tap_ld) begin
         n_ld++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL tap_ld_unexpected: got tap_ld with tap_val %0d, expected no load", tap_val);
         end else begin
            check("tap_ld_val", int'(tap_val), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      phase++;
      E = gen_e();
   endtask

   task automatic wait_locked(input int budget, output int cycles);
      cycles = 0;
      while (!locked && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic wait_ld(input int target, input int budget, input string name);
      int c;
      c = 0;
      while (n_ld < target && c < budget) begin
         tick();
         c++;
      end
      check(name, n_ld, target);
   endtask

   task automatic do_reset();
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      aresetn = 1'b0;
      dly_rdy = 1'b0;
      mode = M_ZERO;
      E = 4'b0000;
      #1;
      check("rst_tap_ld", int'(tap_ld), 0);
      check("rst_tap_val", int'(tap_val), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_sweep_fail", int'(sweep_fail), 0);
      n_ld = 0;
      tick();
      tick();
      aresetn = 1'b1;
      tick();
   endtask

   initial begin
      // Scenario 1: no ready, no activity.
      do_reset();
      repeat (100) tick();
      check("s1_no_ld", n_ld, 0);
      check("s1_tap_val", int'(tap_val), 0);
      check("s1_locked", int'(locked), 0);

      // Scenario 2: one clean phase every 4th cycle locks at tap 0.
      do_reset();
      mode = M_CLEAN; clean_kind = 0;
      exp_q.push_back(0);
      dly_rdy = 1'b1;
      wait_locked(2000, cyc);
      check("s2_lock_latency", cyc, 1043);
      check("s2_tap_val", int'(tap_val), 0);
      check("s2_ld_count", n_ld, 1);
`ifdef RX_ALIGN_STATS_EN
      check("s2_win_total", int'(win_total), 256);
      check("s2_win_peak", int'(win_peak), 1);
`endif

      // Scenario 3: even spread on taps 0-6, clean on tap 7.
      do_reset();
      mode = M_SWEEP; lock_tap = 7; clean_kind = 1;
      for (int t = 0; t <= 7; t++) exp_q.push_back(t);
      dly_rdy = 1'b1;
      wait_locked(9000, cyc);
      check("s3_locked", int'(locked), 1);
      check("s3_tap_val", int'(tap_val), 7);
      check("s3_ld_count", n_ld, 8);
      check("s3_sweep_fail", int'(sweep_fail), 0);

      // Scenario 4: no edges, full sweep and wrap.
      do_reset();
      mode = M_ZERO;
      for (int t = 0; t < 32; t++) exp_q.push_back(t);
      exp_q.push_back(0);
      dly_rdy = 1'b1;
      wait_ld(32, 34000, "s4_reach_tap31");
      check("s4_no_fail_before_31", int'(sweep_fail), 0);
      wait_ld(33, 1200, "s4_wrap_load");
      check("s4_sweep_fail", int'(sweep_fail), 1);
      check("s4_tap_wrap", int'(tap_val), 0);
      check("s4_locked", int'(locked), 0);

      // Scenario 5: lock at tap 3, tolerate a single bad window, drop on two.
      do_reset();
      mode = M_SWEEP; lock_tap = 3; clean_kind = 0;
      for (int t = 0; t <= 3; t++) exp_q.push_back(t);
      dly_rdy = 1'b1;
      wait_locked(5000, cyc);
      check("s5_locked", int'(locked), 1);
      check("s5_tap_val", int'(tap_val), 3);
      mode = M_SPREAD;
      repeat (1025) tick();
      check("s5_one_bad_held", int'(locked), 1);
      mode = M_CLEAN;
      repeat (1025) tick();
      check("s5_recovered", int'(locked), 1);
      mode = M_SPREAD;
      exp_q.push_back(4);
      repeat (1025) tick();
      check("s5_bad_count_reset", int'(locked), 1);
      wait_ld(5, 1100, "s5_reload");
      check("s5_unlocked", int'(locked), 0);
      check("s5_tap_next", int'(tap_val), 4);
`ifdef RX_ALIGN_STATS_EN
      check("s5_relock_cnt", int'(relock_cnt), 1);
`endif

      // Scenario 6a: ready drops mid-MEASURE, then mid-LOCKED.
      do_reset();
      mode = M_SWEEP; lock_tap = 2; clean_kind = 0;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      dly_rdy = 1'b1;
      wait_ld(3, 3000, "s6_reach_tap2");
      repeat (500) tick();
      dly_rdy = 1'b0;
      tick();
      check("s6_drop_locked", int'(locked), 0);
      check("s6_drop_tap_kept", int'(tap_val), 2);
      repeat (30) tick();
      check("s6_no_ld_while_down", n_ld, 3);
      exp_q.push_back(2);
      dly_rdy = 1'b1;
      wait_locked(1500, cyc);
      check("s6_relock", int'(locked), 1);
      check("s6_relock_tap", int'(tap_val), 2);
      check("s6_ld_count", n_ld, 4);
      repeat (300) tick();
      dly_rdy = 1'b0;
      tick();
      check("s6_drop_in_lock", int'(locked), 0);
      check("s6_drop_in_lock_tap", int'(tap_val), 2);
`ifdef RX_ALIGN_STATS_EN
      check("s6_relock_cnt_zero", int'(relock_cnt), 0);
`endif

      // Scenario 6b: reset asserted mid-LOCKED.
      exp_q.push_back(2);
      dly_rdy = 1'b1;
      wait_locked(1500, cyc);
      check("s6b_locked", int'(locked), 1);
      repeat (300) tick();
      aresetn = 1'b0;
      #1;
      check("s6b_rst_locked", int'(locked), 0);
      check("s6b_rst_tap", int'(tap_val), 0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
